// File: rtl/acs_pm_bank_if.sv
// Bus between the branch metric units, the ACS bank and the traceback unit.
interface acs_pm_bank_if #(
  parameter int unsigned N_STATES = 8,
  parameter int unsigned BM_W     = 2,
  parameter int unsigned PM_W     = 8
);
  logic                       start;
  logic                       in_valid;
  logic [N_STATES*2*BM_W-1:0] bm_in;
  logic                       out_valid;
  logic [N_STATES-1:0]        decision;
  logic [N_STATES*PM_W-1:0]   pm_out;
  logic [2:0]                 best_state;
  logic                       sync;

  modport master (
    output start, in_valid, bm_in,
    input  out_valid, decision, pm_out, best_state, sync
  );

  modport slave (
    input  start, in_valid, bm_in,
    output out_valid, decision, pm_out, best_state, sync
  );
endinterface

// File: rtl/acs_pm_bank.sv
// Add-compare-select bank for the 8-state rate-1/2 Viterbi decoder.
// One symbol per in_valid: add branch metrics, pick survivors, normalise
// so the minimum metric is zero, and register everything for one cycle.
module acs_pm_bank #(
  parameter int unsigned N_STATES = 8,
  parameter int unsigned BM_W     = 2,
  parameter int unsigned PM_W     = 8,
  parameter int unsigned PM_INIT  = 64
) (
  input logic           clk,
  input logic           rst_n,
  acs_pm_bank_if.slave  bus
);

  localparam int unsigned SW = $clog2(N_STATES);

  function automatic logic [N_STATES*PM_W-1:0] init_metrics();
    logic [N_STATES*PM_W-1:0] v;
    v = '0;
    for (int unsigned s = 1; s < N_STATES; s++) begin
      v[s*PM_W +: PM_W] = PM_W'(PM_INIT);
    end
    return v;
  endfunction

  localparam logic [N_STATES*PM_W-1:0] PM_INIT_VEC = init_metrics();

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state_q, state_n;
  logic [1:0]               cnt_q, cnt_nxt;
  logic [N_STATES*PM_W-1:0] pm_q, pm_nxt;
  logic [N_STATES-1:0]      dec_q, dec_nxt;
  logic [SW-1:0]            best_q, best_nxt;
  logic                     ov_q;
  logic                     accept;
  logic [PM_W-1:0]          new_pm [N_STATES];
  logic [PM_W-1:0]          m;
  logic [SW-1:0]            p0, p1;
  logic [PM_W:0]            c0, c1;
  logic [PM_W-1:0]          s0, s1;

  // Symbol-count FSM: start always returns to IDLE and drops any coincident symbol.
  always_comb begin
    state_n = state_q;
    accept  = bus.in_valid && !bus.start;
    cnt_nxt = cnt_q;
    if (bus.start) begin
      state_n = IDLE;
    end else if (bus.in_valid) begin
      state_n = RUN;
      if (state_q == IDLE) cnt_nxt = 2'd1;
      else if (cnt_q != 2'd3) cnt_nxt = cnt_q + 2'd1;
    end
  end

  // Add-compare-select for every state, then normalise against the overall minimum.
  always_comb begin
    new_pm   = '{default: '0};
    dec_nxt  = '0;
    pm_nxt   = '0;
    best_nxt = '0;
    m        = '1;
    p0 = '0; p1 = '0; c0 = '0; c1 = '0; s0 = '0; s1 = '0;
    for (int unsigned s = 0; s < N_STATES; s++) begin
      p0 = SW'(s >> 1);
      p1 = p0 + SW'(N_STATES / 2);
      c0 = {1'b0, pm_q[p0*PM_W +: PM_W]} + (PM_W+1)'(bus.bm_in[(2*s)*BM_W +: BM_W]);
      c1 = {1'b0, pm_q[p1*PM_W +: PM_W]} + (PM_W+1)'(bus.bm_in[(2*s+1)*BM_W +: BM_W]);
      // Clamp before comparing so two saturated candidates tie and resolve to p0.
      s0 = c0[PM_W] ? '1 : c0[PM_W-1:0];
      s1 = c1[PM_W] ? '1 : c1[PM_W-1:0];
      dec_nxt[s] = (s1 < s0);
      new_pm[s]  = (s1 < s0) ? s1 : s0;
    end
    // Strict less-than keeps the lowest index among equal minima.
    for (int unsigned s = 0; s < N_STATES; s++) begin
      if (new_pm[s] < m) begin
        m        = new_pm[s];
        best_nxt = SW'(s);
      end
    end
    if (new_pm[0] == '1 && m == '1) best_nxt = '0;
    for (int unsigned s = 0; s < N_STATES; s++) begin
      pm_nxt[s*PM_W +: PM_W] = new_pm[s] - m;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Metric, decision and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q   <= PM_INIT_VEC;
      dec_q  <= '0;
      best_q <= '0;
      ov_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (bus.start) begin
      pm_q   <= PM_INIT_VEC;
      dec_q  <= '0;
      best_q <= '0;
      ov_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      pm_q   <= pm_nxt;
      dec_q  <= dec_nxt;
      best_q <= best_nxt;
      ov_q   <= 1'b1;
      cnt_q  <= cnt_nxt;
    end else begin
      ov_q   <= 1'b0;
    end
  end

  assign bus.out_valid  = ov_q;
  assign bus.decision   = dec_q;
  assign bus.pm_out     = pm_q;
  assign bus.best_state = 3'(best_q);
  assign bus.sync       = (cnt_q == 2'd3);

endmodule

// File: tb/tb_acs_pm_bank.sv
// Bench for acs_pm_bank: one DUT at the default initial metric and one with a
// near-maximum initial metric to exercise candidate clamping.
module tb_acs_pm_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] bm = '0;

  int checks = 0;
  int errors = 0;

  acs_pm_bank_if bus_a ();
  acs_pm_bank_if bus_b ();

  assign bus_a.start    = start;
  assign bus_a.in_valid = in_valid;
  assign bus_a.bm_in    = bm;
  assign bus_b.start    = start;
  assign bus_b.in_valid = in_valid;
  assign bus_b.bm_in    = bm;

  acs_pm_bank dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  acs_pm_bank #(.PM_INIT(254)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model state, per DUT.
  int init_pm [2] = '{64, 254};
  int mpm   [2][8];
  int mdec  [2];
  int mbest [2];
  int mov;
  int mcnt;

  function automatic int bmv(input logic [31:0] v, input int s, input int b);
    logic [31:0] t;
    t = v >> ((2*s + b) * 2);
    return int'(t[1:0]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 8; s++) mpm[d][s] = (s == 0) ? 0 : init_pm[d];
      mdec[d] = 0;
      mbest[d] = 0;
    end
    mov = 0;
    mcnt = 0;
  endtask

  task automatic model_edge();
    int c0, c1, nw[8], mn;
    if (start) begin
      model_reset();
    end else if (in_valid) begin
      for (int d = 0; d < 2; d++) begin
        mdec[d] = 0;
        for (int s = 0; s < 8; s++) begin
          c0 = mpm[d][s/2] + bmv(bm, s, 0);
          c1 = mpm[d][s/2 + 4] + bmv(bm, s, 1);
          if (c0 > 255) c0 = 255;
          if (c1 > 255) c1 = 255;
          if (c1 < c0) begin
            mdec[d] |= (1 << s);
            nw[s] = c1;
          end else begin
            nw[s] = c0;
          end
        end
        mn = 1000;
        foreach (nw[s]) if (nw[s] < mn) mn = nw[s];
        mbest[d] = -1;
        for (int s = 0; s < 8; s++) begin
          if (nw[s] == mn && mbest[d] < 0) mbest[d] = s;
          mpm[d][s] = nw[s] - mn;
        end
      end
      mov = 1;
      if (mcnt < 3) mcnt++;
    end else begin
      mov = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] e;
    for (int d = 0; d < 2; d++) begin
      e = '0;
      for (int s = 0; s < 8; s++) e[s*8 +: 8] = 8'(mpm[d][s]);
      chk({tag, (d == 0) ? "_a_pm" : "_b_pm"}, (d == 0) ? bus_a.pm_out : bus_b.pm_out, e);
      chk({tag, (d == 0) ? "_a_dec" : "_b_dec"},
          64'((d == 0) ? bus_a.decision : bus_b.decision), 64'(mdec[d]));
      chk({tag, (d == 0) ? "_a_best" : "_b_best"},
          64'((d == 0) ? bus_a.best_state : bus_b.best_state), 64'(mbest[d]));
      chk({tag, (d == 0) ? "_a_ov" : "_b_ov"},
          64'((d == 0) ? bus_a.out_valid : bus_b.out_valid), 64'(mov));
      chk({tag, (d == 0) ? "_a_sync" : "_b_sync"},
          64'((d == 0) ? bus_a.sync : bus_b.sync), 64'(mcnt == 3));
    end
  endtask

  task automatic step(input string tag, input logic st, input logic v, input logic [31:0] b);
    start = st;
    in_valid = v;
    bm = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero metrics from reset.
    step("bm0", 1'b0, 1'b1, 32'h0);
    chk("bm0_pm_const", bus_a.pm_out, 64'h4040404040400000);
    chk("bm0_dec_const", 64'(bus_a.decision), 64'h0);
    chk("bm0_ov_const", 64'(bus_a.out_valid), 64'h1);
    step("hold", 1'b0, 1'b0, 32'hFFFF_FFFF);

    // All-one metrics after a restart.
    step("restart1", 1'b1, 1'b0, 32'h0);
    step("bm1", 1'b0, 1'b1, 32'h5555_5555);
    chk("bm1_pm_const", bus_a.pm_out, 64'h4040404040400000);

    // Only state 0 via p0 is penalised: state 1 becomes best.
    step("restart2", 1'b1, 1'b0, 32'h0);
    step("s0pen", 1'b0, 1'b1, 32'h0000_0003);
    chk("s0pen_best_const", 64'(bus_a.best_state), 64'h1);
    chk("s0pen_pm0_const", 64'(bus_a.pm_out[7:0]), 64'h3);

    // Sync after three symbols, then start with in_valid high drops the symbol.
    step("restart3", 1'b1, 1'b0, 32'h0);
    step("sync1", 1'b0, 1'b1, $urandom);
    step("sync2", 1'b0, 1'b1, $urandom);
    chk("sync_low_const", 64'(bus_a.sync), 64'h0);
    step("sync3", 1'b0, 1'b1, $urandom);
    chk("sync_high_const", 64'(bus_a.sync), 64'h1);
    step("sync4", 1'b0, 1'b1, $urandom);
    step("start_drop", 1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("start_drop_ov_const", 64'(bus_a.out_valid), 64'h0);

    // Saturation on the high-initial DUT: 254+3 clamps to 255 on both branches (tie -> p0).
    step("sat", 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("sat_pm2_const", 64'(bus_b.pm_out[23:16]), 64'd252);
    chk("sat_dec_const", 64'(bus_b.decision), 64'h0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), $urandom);
    end

    // Asynchronous reset pulse between edges.
    step("pre_rst", 1'b0, 1'b1, $urandom);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    step("post_rst", 1'b0, 1'b1, 32'h0);
    chk("post_rst_pm_const", bus_a.pm_out, 64'h4040404040400000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
